// File: rtl/ac_datapath.sv
// ac_datapath: accumulator register stage of the basic computer.
// Holds the WIDTH-bit AC, the E (carry) flip-flop and a sticky strobe-conflict
// flag. Applies the decoded accumulator and E-register strobes on each rising
// clock edge. Status flags are derived combinationally from the registered state.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   AND/ADD/LDA/COM/INP function selects, effective only together with LD
//   LD                  load-enable for the adder/logic result
//   INC, CLR, CIR, CIL  remaining AC-group strobes
//   CLE, CME            E-group strobes
//   DR, INPR            operands
//   AC, E, ERR          registered outputs
//   AC_ZERO, AC_NEG,    combinational status flags
//   E_ZERO
module ac_datapath #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned INPR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              AND,
    input  logic              ADD,
    input  logic              LDA,
    input  logic              COM,
    input  logic              INP,
    input  logic              LD,
    input  logic              INC,
    input  logic              CLR,
    input  logic              CIR,
    input  logic              CIL,
    input  logic              CLE,
    input  logic              CME,
    input  logic [WIDTH-1:0]  DR,
    input  logic [INPR_W-1:0] INPR,
    output logic [WIDTH-1:0]  AC,
    output logic              E,
    output logic              AC_ZERO,
    output logic              AC_NEG,
    output logic              E_ZERO,
    output logic              ERR
);

    logic [WIDTH-1:0] ac_q, ac_d;
    logic             e_q, e_d;
    logic             err_q, err_d;

    logic [2:0]       ac_cnt;
    logic [2:0]       sel_cnt;
    logic             conflict;
    logic             e_by_op;
    logic [WIDTH:0]   sum;

    assign ac_cnt  = {2'b00, CLR} + {2'b00, LD} + {2'b00, INC} + {2'b00, CIR} + {2'b00, CIL};
    assign sel_cnt = {2'b00, AND} + {2'b00, ADD} + {2'b00, LDA} + {2'b00, COM} + {2'b00, INP};

    // The LD select check applies whenever LD is asserted, even if LD loses to CLR.
    assign conflict = (ac_cnt > 3'd1) || (LD && (sel_cnt != 3'd1)) || (CLE && CME);

    assign sum = {1'b0, ac_q} + {1'b0, DR};

    always_comb begin
        ac_d    = ac_q;
        e_d     = e_q;
        e_by_op = 1'b0;

        if (CLR) begin
            ac_d = '0;
        end else if (LD) begin
            if (AND) begin
                ac_d = ac_q & DR;
            end else if (ADD) begin
                ac_d    = sum[WIDTH-1:0];
                e_d     = sum[WIDTH];
                e_by_op = 1'b1;
            end else if (LDA) begin
                ac_d = DR;
            end else if (COM) begin
                ac_d = ~ac_q;
            end else if (INP) begin
                ac_d = WIDTH'(INPR);
            end
        end else if (INC) begin
            ac_d = ac_q + WIDTH'(1);
        end else if (CIR) begin
            ac_d    = {e_q, ac_q[WIDTH-1:1]};
            e_d     = ac_q[0];
            e_by_op = 1'b1;
        end else if (CIL) begin
            ac_d    = {ac_q[WIDTH-2:0], e_q};
            e_d     = ac_q[WIDTH-1];
            e_by_op = 1'b1;
        end

        // E-group strobes yield to an executing operation that writes E itself.
        if (!e_by_op) begin
            if (CLE) begin
                e_d = 1'b0;
            end else if (CME) begin
                e_d = ~e_q;
            end
        end

        err_d = err_q | conflict;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_q  <= '0;
            e_q   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ac_q  <= ac_d;
            e_q   <= e_d;
            err_q <= err_d;
        end
    end

    assign AC      = ac_q;
    assign E       = e_q;
    assign ERR     = err_q;
    assign AC_ZERO = (ac_q == '0);
    assign AC_NEG  = ac_q[WIDTH-1];
    assign E_ZERO  = ~e_q;

endmodule

// File: tb/tb_ac_datapath.sv
// Self-checking bench for ac_datapath: directed scenarios plus randomized
// strobes checked against an arithmetic reference model.
module tb_ac_datapath;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_and, s_add, s_lda, s_com, s_inp, s_ld;
    logic        s_inc, s_clr, s_cir, s_cil, s_cle, s_cme;
    logic [15:0] dr;
    logic [7:0]  inpr;
    logic [15:0] ac;
    logic        e, ac_zero, ac_neg, e_zero, err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    int unsigned m_ac;
    int unsigned m_e;
    int unsigned m_err;

    // Strobe vector order: {AND,ADD,LDA,COM,INP,LD,INC,CLR,CIR,CIL,CLE,CME}
    localparam logic [11:0] B_AND = 12'h800, B_ADD = 12'h400, B_LDA = 12'h200;
    localparam logic [11:0] B_COM = 12'h100, B_INP = 12'h080, B_LD  = 12'h040;
    localparam logic [11:0] B_INC = 12'h020, B_CLR = 12'h010, B_CIR = 12'h008;
    localparam logic [11:0] B_CIL = 12'h004, B_CLE = 12'h002, B_CME = 12'h001;

    ac_datapath #(.WIDTH(16), .INPR_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .AND     (s_and),
        .ADD     (s_add),
        .LDA     (s_lda),
        .COM     (s_com),
        .INP     (s_inp),
        .LD      (s_ld),
        .INC     (s_inc),
        .CLR     (s_clr),
        .CIR     (s_cir),
        .CIL     (s_cil),
        .CLE     (s_cle),
        .CME     (s_cme),
        .DR      (dr),
        .INPR    (inpr),
        .AC      (ac),
        .E       (e),
        .AC_ZERO (ac_zero),
        .AC_NEG  (ac_neg),
        .E_ZERO  (e_zero),
        .ERR     (err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [11:0] s, input logic [15:0] d, input logic [7:0] p);
        {s_and, s_add, s_lda, s_com, s_inp, s_ld, s_inc, s_clr, s_cir, s_cil, s_cle, s_cme} = s;
        dr   = d;
        inpr = p;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(12'h000, 16'h0000, 8'h00);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        m_ac = 0; m_e = 0; m_err = 0;
    endtask

    // Behavioural model: priorities and arithmetic taken straight from the rules.
    task automatic model_step(input logic [11:0] s, input logic [15:0] d, input logic [7:0] p);
        int n_ac, n_sel;
        int unsigned v, old_ac, old_e;
        bit e_written;
        n_ac  = int'(s[6]) + int'(s[5]) + int'(s[4]) + int'(s[3]) + int'(s[2]);
        n_sel = int'(s[11]) + int'(s[10]) + int'(s[9]) + int'(s[8]) + int'(s[7]);
        if (n_ac > 1 || (s[6] && n_sel != 1) || (s[1] && s[0])) m_err = 1;
        old_ac = m_ac; old_e = m_e; e_written = 0;
        if (s[4]) m_ac = 0;
        else if (s[6]) begin
            if (s[11]) m_ac = old_ac & 32'(d);
            else if (s[10]) begin
                v = old_ac + 32'(d);
                m_ac = v % 65536; m_e = v / 65536; e_written = 1;
            end
            else if (s[9]) m_ac = 32'(d);
            else if (s[8]) m_ac = 65535 - old_ac;
            else if (s[7]) m_ac = 32'(p);
        end
        else if (s[5]) m_ac = (old_ac + 1) % 65536;
        else if (s[3]) begin
            v = old_e * 65536 + old_ac;   // 17-bit {E,AC} shifted right
            m_ac = v / 2; m_e = v % 2; e_written = 1;
        end
        else if (s[2]) begin
            v = old_ac * 2 + old_e;       // 17-bit {AC,E} shifted left
            m_ac = v % 65536; m_e = v / 65536; e_written = 1;
        end
        if (!e_written) begin
            if (s[1]) m_e = 0;
            else if (s[0]) m_e = 1 - old_e;
        end
    endtask

    task automatic test_reset();
        drive(B_LD | B_LDA, 16'hFFFF, 8'h00);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ac !== 16'h0000 || e !== 1'b0 || err !== 1'b0 || ac_zero !== 1'b1)
                $display("FAIL reset[%0d]: AC=%h E=%b ERR=%b AC_ZERO=%b, want 0000 0 0 1",
                         i, ac, e, err, ac_zero);
            else n_pass++;
            cyc();
        end
        n_checks++;
        if (ac_neg !== 1'b0 || e_zero !== 1'b1)
            $display("FAIL reset_flags: AC_NEG=%b E_ZERO=%b, want 0 1", ac_neg, e_zero);
        else n_pass++;
        drive(12'h000, 16'h0000, 8'h00);
        rst_n = 1'b1;
        m_ac = 0; m_e = 0; m_err = 0;
        cyc();
    endtask

    task automatic test_add_carry();
        do_reset();
        drive(B_LD | B_LDA, 16'hFFF0, 8'h00); cyc();
        n_checks++;
        if (ac !== 16'hFFF0) $display("FAIL lda: AC=%h want FFF0", ac); else n_pass++;
        drive(B_LD | B_ADD, 16'h0011, 8'h00); cyc();
        n_checks++;
        if (ac !== 16'h0001 || e !== 1'b1 || err !== 1'b0)
            $display("FAIL add_carry: AC=%h E=%b ERR=%b, want 0001 1 0", ac, e, err);
        else n_pass++;
    endtask

    task automatic test_logic_inc();
        do_reset();
        drive(B_LD | B_LDA | B_CME, 16'hFFFF, 8'h00); cyc();
        n_checks++;
        if (ac !== 16'hFFFF || e !== 1'b1) $display("FAIL preload: AC=%h E=%b, want FFFF 1", ac, e);
        else n_pass++;
        drive(B_INC, 16'h0000, 8'h00); cyc();
        n_checks++;
        if (ac !== 16'h0000 || e !== 1'b1 || ac_zero !== 1'b1)
            $display("FAIL inc_wrap: AC=%h E=%b AC_ZERO=%b, want 0000 1 1", ac, e, ac_zero);
        else n_pass++;
        drive(B_LD | B_COM, 16'h0000, 8'h00); cyc();
        n_checks++;
        if (ac !== 16'hFFFF || ac_neg !== 1'b1)
            $display("FAIL com: AC=%h AC_NEG=%b, want FFFF 1", ac, ac_neg);
        else n_pass++;
        drive(B_LD | B_AND, 16'h0F0F, 8'h00); cyc();
        n_checks++;
        if (ac !== 16'h0F0F || err !== 1'b0)
            $display("FAIL and: AC=%h ERR=%b, want 0F0F 0", ac, err);
        else n_pass++;
        drive(B_INC, 16'h0000, 8'h00); cyc(); cyc(); cyc();
        n_checks++;
        if (ac !== 16'h0F12) $display("FAIL inc_x3: AC=%h want 0F12", ac); else n_pass++;
    endtask

    task automatic test_circulate();
        do_reset();
        drive(B_LD | B_LDA | B_CLE, 16'h8001, 8'h00); cyc();
        drive(B_CIL, 16'h0000, 8'h00); cyc();
        n_checks++;
        if (ac !== 16'h0002 || e !== 1'b1) $display("FAIL cil: AC=%h E=%b, want 0002 1", ac, e);
        else n_pass++;
        drive(B_CIR, 16'h0000, 8'h00); cyc();
        n_checks++;
        if (ac !== 16'h8001 || e !== 1'b0) $display("FAIL cir: AC=%h E=%b, want 8001 0", ac, e);
        else n_pass++;
        drive(B_CME, 16'h0000, 8'h00); cyc();
        n_checks++;
        if (e !== 1'b1 || e_zero !== 1'b0 || err !== 1'b0)
            $display("FAIL cme: E=%b E_ZERO=%b ERR=%b, want 1 0 0", e, e_zero, err);
        else n_pass++;
        drive(B_CLE | B_CME, 16'h0000, 8'h00); cyc();
        n_checks++;
        if (e !== 1'b0 || err !== 1'b1) $display("FAIL cle_cme: E=%b ERR=%b, want 0 1", e, err);
        else n_pass++;
    endtask

    task automatic test_conflict();
        do_reset();
        drive(B_LD | B_LDA, 16'h1234, 8'h00); cyc();
        drive(B_CLR | B_INC, 16'h0000, 8'h00); cyc();
        n_checks++;
        if (ac !== 16'h0000 || err !== 1'b1)
            $display("FAIL clr_inc: AC=%h ERR=%b, want 0000 1", ac, err);
        else n_pass++;
        drive(12'h000, 16'h0000, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_checks++;
            if (err !== 1'b1 || ac !== 16'h0000)
                $display("FAIL err_sticky[%0d]: ERR=%b AC=%h, want 1 0000", i, err, ac);
            else n_pass++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b0) $display("FAIL err_async_clear: ERR=%b want 0", err); else n_pass++;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_inp_ld();
        do_reset();
        drive(B_LD | B_INP, 16'hFFFF, 8'hA5); cyc();
        n_checks++;
        if (ac !== 16'h00A5 || err !== 1'b0) $display("FAIL inp: AC=%h ERR=%b, want 00A5 0", ac, err);
        else n_pass++;
        drive(B_LD, 16'hFFFF, 8'h5A); cyc();
        n_checks++;
        if (ac !== 16'h00A5 || err !== 1'b1)
            $display("FAIL ld_nosel: AC=%h ERR=%b, want 00A5 1", ac, err);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(B_LD | B_LDA | B_CME, 16'hBEEF, 8'h00); cyc();
        drive(B_INC, 16'h0000, 8'h00);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ac !== 16'h0000 || e !== 1'b0)
            $display("FAIL mid_reset: AC=%h E=%b, want 0000 0", ac, e);
        else n_pass++;
        cyc();
        rst_n = 1'b1;
        drive(12'h000, 16'h0000, 8'h00);
    endtask

    task automatic test_random();
        logic [11:0] s;
        logic [15:0] d;
        logic [7:0]  p;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 80 == 79) do_reset();
            s = '0;
            case ($urandom_range(0, 7))
                0: s = B_INC;
                1: s = B_CIR;
                2: s = B_CIL;
                3: s = B_CLR;
                4: s = B_LD | (12'h080 << $urandom_range(0, 4));
                5: s = B_LD | (12'h080 << $urandom_range(0, 4));
                default: s = '0;
            endcase
            s = s | (($urandom_range(0, 3) == 0) ? B_CLE : 12'h000);
            s = s | (($urandom_range(0, 3) == 0) ? B_CME : 12'h000);
            if ($urandom_range(0, 15) == 0) s = s ^ (12'h001 << $urandom_range(0, 11));
            d = 16'($urandom);
            p = 8'($urandom);
            drive(s, d, p);
            model_step(s, d, p);
            cyc();
            n_checks++;
            if (32'(ac) !== m_ac || 32'(e) !== m_e || 32'(err) !== m_err)
                $display("FAIL random[%0d] s=%h: AC=%h E=%b ERR=%b, want %h %0d %0d",
                         i, s, ac, e, err, m_ac[15:0], m_e, m_err);
            else n_pass++;
            n_checks++;
            if (ac_zero !== (m_ac == 0) || ac_neg !== (m_ac >= 32768) || e_zero !== (m_e == 0))
                $display("FAIL random_flags[%0d]: Z=%b N=%b EZ=%b, want %b %b %b", i,
                         ac_zero, ac_neg, e_zero, m_ac == 0, m_ac >= 32768, m_e == 0);
            else n_pass++;
        end
    endtask

    initial begin
        drive(12'h000, 16'h0000, 8'h00);
        test_reset();
        test_add_carry();
        test_logic_inc();
        test_circulate();
        test_conflict();
        test_inp_ld();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
